wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and register file at the consumer end of the MEM/WB pipeline register. Takes the registered MEM/WB bundle, selects memory or ALU data, applies per-byte-lane write enables and overflow-trap suppression, and commits into a 32x32 register file. Provides the two asynchronous read ports used by instruction decode, with optional same-cycle write-through bypass. Keeps sticky overflow-exception status for the control unit.

## Interface
Parameters:
- CNT_W, 8, width of the saturating overflow-exception counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous and active-low.
- overflow_f  in  1  ALU overflow flag of the instruction in WB.
- Dout_f  in  32  memory load data.
- result_f  in  32  ALU result.
- Rw_f  in  5  destination register number.
- RegWr_f  in  1  master register write enable.
- RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f  in  1 each  byte-lane enables for bits [31:24], [23:16], [15:8], [7:0].
- MemtoReg_f  in  1  1 selects Dout_f, 0 selects result_f.
- OvSel_f  in  1  1 means the instruction traps on overflow (signed add/sub).
- Ra, Rb  in  5  read addresses.
- busA, busB  out  32  read data.
- exc_clr  in  1  clears ov_exc.
- ov_exc  out  1  sticky overflow-exception flag.
- ov_rw  out  5  Rw_f of the most recent trapped instruction.
- ov_cnt  out  CNT_W  saturating count of trapped instructions.

## Operation
- wdata = MemtoReg_f ? Dout_f : result_f.
- trap = RegWr_f & OvSel_f & overflow_f.
- commit = RegWr_f & ~trap & (Rw_f != 0).
- On commit, for each lane k (1..4) with RegWr_kf = 1, byte k-1 of reg[Rw_f] takes byte k-1 of wdata; lanes with enable 0 keep the old byte. All lane enables 0 with RegWr_f = 1: no change, not an error.
- reg[0] is hardwired 0. Writes to it are discarded, and reads of it return 0.
- On trap: no register write; ov_exc set to 1; ov_rw set to Rw_f; ov_cnt increments, saturating at 2^CNT_W-1.
- exc_clr = 1 clears ov_exc only. ov_rw and ov_cnt hold. If trap and exc_clr occur in the same cycle, the set wins and ov_exc = 1.
- overflow_f with OvSel_f = 0 is ignored: normal commit, no status change.
- busA/busB = reg[Ra]/reg[Rb], combinational. Bypass applies per Configuration.

## Timing
- Reset: when rst_n = 0 at a posedge, all 31 registers, ov_exc, ov_rw and ov_cnt become 0. Commits and traps in that cycle are discarded. busA/busB read 0 from the next cycle until written.
- Reset asserted mid-stream: the bundle present on that edge is lost. Bundles resume on the first edge with rst_n = 1.
- Write latency: data is committed at the posedge that samples the bundle. A read issued after that edge returns the new value, a latency of 1 cycle without bypass.
- Status latency: ov_exc, ov_rw and ov_cnt are registered and update at the same edge as the trapped instruction.
- Read ports have no clocked latency. busA/busB settle combinationally after Ra, Rb or register state change.
- Simultaneous write and read of the same register in one cycle: result depends on the macro (see Configuration).

## Configuration
- WB_BYPASS_EN defined: when commit = 1 and Ra (Rb) equals Rw_f, busA (busB) returns the merged value for the current cycle. Enabled lanes come from wdata, and the other lanes come from the stored register. This removes the WB-to-ID hazard.
- WB_BYPASS_EN undefined: busA/busB always return the stored register contents. A same-cycle read sees the old value, and the new value is visible after the edge. There is no bypass logic.
- Trapped writes and writes to $0 are never bypassed in either build.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with RegWr_f = 1, Rw_f = 5, all lanes on -> reg[5] = 0, ov_exc = 0, ov_cnt = 0 after release.
- Full-word select: result_f = 0x12345678, MemtoReg_f = 0, Rw_f = 3, all lanes -> busA (Ra = 3) = 0x12345678. Then Dout_f = 0xCAFEBABE, MemtoReg_f = 1 -> 0xCAFEBABE.
- Byte lanes: reg[4] = 0xFFFFFFFF, then write 0x000000AA with only RegWr_1f -> 0xFFFFFFAA. Then write 0x11000000 with only RegWr_4f -> 0x11FFFFAA.
- Overflow trap: reg[7] = 0x1, then write 0x80000000 with OvSel_f = 1, overflow_f = 1 -> reg[7] stays 0x1, ov_exc = 1, ov_rw = 7, ov_cnt = 1. Trap plus exc_clr in the same cycle -> ov_exc = 1, ov_cnt = 2. exc_clr alone -> ov_exc = 0.
- $0 and saturation: write 0xDEADBEEF to Rw_f = 0 -> busA (Ra = 0) = 0. Issue 300 traps with CNT_W = 8 -> ov_cnt = 255.
- Bypass: write 0x55 to reg[9] with Ra = 9 in the same cycle. With WB_BYPASS_EN, busA = 0x55 before the edge. Without it, busA = old value before the edge and 0x55 after.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, byte-lane merge and 32x32 register file with sticky overflow-trap status.
// Optional macro WB_BYPASS_EN adds same-cycle write-through bypass on busA/busB.
module wb_regfile #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             overflow_f,
  input  logic [31:0]      Dout_f,
  input  logic [31:0]      result_f,
  input  logic [4:0]       Rw_f,
  input  logic             RegWr_f,
  input  logic             RegWr_4f,
  input  logic             RegWr_3f,
  input  logic             RegWr_2f,
  input  logic             RegWr_1f,
  input  logic             MemtoReg_f,
  input  logic             OvSel_f,
  input  logic [4:0]       Ra,
  input  logic [4:0]       Rb,
  output logic [31:0]      busA,
  output logic [31:0]      busB,
  input  logic             exc_clr,
  output logic             ov_exc,
  output logic [4:0]       ov_rw,
  output logic [CNT_W-1:0] ov_cnt
);
  logic [31:0] regs_q [32];
  logic ov_exc_q, ov_exc_d;
  logic [4:0] ov_rw_q, ov_rw_d;
  logic [CNT_W-1:0] ov_cnt_q, ov_cnt_d;
  logic [31:0] wdata, mask, merged, rd_a, rd_b;
  logic trap, commit;
  always_comb begin
    wdata = MemtoReg_f ? Dout_f : result_f;
    trap = RegWr_f & OvSel_f & overflow_f;
    commit = rst_n & RegWr_f & ~trap & (Rw_f != 5'd0);
    mask = {{8{RegWr_4f}}, {8{RegWr_3f}}, {8{RegWr_2f}}, {8{RegWr_1f}}};
    merged = (wdata & mask) | (regs_q[Rw_f] & ~mask);
    // a same-cycle trap wins over exc_clr
    ov_exc_d = trap | (ov_exc_q & ~exc_clr);
    ov_rw_d = trap ? Rw_f : ov_rw_q;
    ov_cnt_d = (trap && ov_cnt_q != '1) ? ov_cnt_q + CNT_W'(1) : ov_cnt_q;
    rd_a = (Ra == 5'd0) ? '0 : regs_q[Ra];
    rd_b = (Rb == 5'd0) ? '0 : regs_q[Rb];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      ov_exc_q <= 1'b0;
      ov_rw_q <= '0;
      ov_cnt_q <= '0;
    end else begin
      if (commit) regs_q[Rw_f] <= merged;
      ov_exc_q <= ov_exc_d;
      ov_rw_q <= ov_rw_d;
      ov_cnt_q <= ov_cnt_d;
    end
  end
`ifdef WB_BYPASS_EN
  assign busA = (commit && Ra == Rw_f) ? merged : rd_a;
  assign busB = (commit && Rb == Rw_f) ? merged : rd_b;
`else
  assign busA = rd_a;
  assign busB = rd_b;
`endif
  assign ov_exc = ov_exc_q;
  assign ov_rw = ov_rw_q;
  assign ov_cnt = ov_cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven directed vectors plus hand sequences for reset, bypass and saturation.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n;
  logic overflow_f;
  logic [31:0] Dout_f, result_f;
  logic [4:0] Rw_f;
  logic RegWr_f, RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f;
  logic MemtoReg_f, OvSel_f;
  logic [4:0] Ra, Rb;
  logic [31:0] busA, busB;
  logic exc_clr;
  logic ov_exc;
  logic [4:0] ov_rw;
  logic [7:0] ov_cnt;
  int checks = 0;
  int failures = 0;

  wb_regfile #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .overflow_f(overflow_f), .Dout_f(Dout_f), .result_f(result_f),
    .Rw_f(Rw_f), .RegWr_f(RegWr_f), .RegWr_4f(RegWr_4f), .RegWr_3f(RegWr_3f),
    .RegWr_2f(RegWr_2f), .RegWr_1f(RegWr_1f), .MemtoReg_f(MemtoReg_f), .OvSel_f(OvSel_f),
    .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB), .exc_clr(exc_clr),
    .ov_exc(ov_exc), .ov_rw(ov_rw), .ov_cnt(ov_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mtr;
    logic [31:0] dout;
    logic [31:0] res;
    logic [4:0] rw;
    logic wr;
    logic [3:0] ln;
    logic ovs;
    logic ovf;
    logic clr;
    logic [4:0] ra;
    logic [31:0] ea;
    logic ee;
    logic [4:0] erw;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    RegWr_f = 1'b0;
    {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f} = 4'h0;
    OvSel_f = 1'b0;
    overflow_f = 1'b0;
    exc_clr = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    MemtoReg_f = v.mtr;
    Dout_f = v.dout;
    result_f = v.res;
    Rw_f = v.rw;
    RegWr_f = v.wr;
    {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f} = v.ln;
    OvSel_f = v.ovs;
    overflow_f = v.ovf;
    exc_clr = v.clr;
    Ra = v.ra;
    Rb = v.ra;
  endtask

  task automatic check_status(input string tag, input logic ee, input logic [4:0] erw, input logic [7:0] ec);
    check({tag, " ov_exc"}, {31'd0, ov_exc}, {31'd0, ee});
    check({tag, " ov_rw"}, {27'd0, ov_rw}, {27'd0, erw});
    check({tag, " ov_cnt"}, {24'd0, ov_cnt}, {24'd0, ec});
  endtask

  initial begin
    //          mtr dout          res           rw  wr ln    ovs ovf clr ra  ea            ee rw  cnt
    vecs[0]  = '{0, 32'h0,        32'h12345678, 3,  1, 4'hF, 0,  0,  0,  3,  32'h12345678, 0, 0,  0};
    vecs[1]  = '{1, 32'hCAFEBABE, 32'h0,        3,  1, 4'hF, 0,  0,  0,  3,  32'hCAFEBABE, 0, 0,  0};
    vecs[2]  = '{0, 32'h0,        32'hFFFFFFFF, 4,  1, 4'hF, 0,  0,  0,  4,  32'hFFFFFFFF, 0, 0,  0};
    vecs[3]  = '{0, 32'h0,        32'h000000AA, 4,  1, 4'h1, 0,  0,  0,  4,  32'hFFFFFFAA, 0, 0,  0};
    vecs[4]  = '{0, 32'h0,        32'h11000000, 4,  1, 4'h8, 0,  0,  0,  4,  32'h11FFFFAA, 0, 0,  0};
    vecs[5]  = '{0, 32'h0,        32'h00000001, 7,  1, 4'hF, 0,  0,  0,  7,  32'h00000001, 0, 0,  0};
    vecs[6]  = '{0, 32'h0,        32'h80000000, 7,  1, 4'hF, 1,  1,  0,  7,  32'h00000001, 1, 7,  1};
    vecs[7]  = '{0, 32'h0,        32'h80000000, 7,  1, 4'hF, 1,  1,  1,  7,  32'h00000001, 1, 7,  2};
    vecs[8]  = '{0, 32'h0,        32'h0,        7,  0, 4'h0, 0,  0,  1,  7,  32'h00000001, 0, 7,  2};
    vecs[9]  = '{0, 32'h0,        32'h0000BEEF, 7,  1, 4'hF, 0,  1,  0,  7,  32'h0000BEEF, 0, 7,  2};
    vecs[10] = '{0, 32'h0,        32'hDEADBEEF, 0,  1, 4'hF, 0,  0,  0,  0,  32'h00000000, 0, 7,  2};
    vecs[11] = '{0, 32'h0,        32'h00000000, 3,  0, 4'hF, 0,  0,  0,  3,  32'hCAFEBABE, 0, 7,  2};
    vecs[12] = '{0, 32'h0,        32'h00000000, 3,  1, 4'h0, 0,  0,  0,  3,  32'hCAFEBABE, 0, 7,  2};
    vecs[13] = '{0, 32'h0,        32'hABCDEF01, 4,  1, 4'h6, 0,  0,  0,  4,  32'h11CDEFAA, 0, 7,  2};
    vecs[14] = '{0, 32'h0,        32'h12121212, 9,  1, 4'hF, 1,  1,  0,  9,  32'h00000000, 1, 9,  3};

    idle();
    MemtoReg_f = 1'b0;
    Dout_f = '0;
    rst_n = 1'b0;
    RegWr_f = 1'b1;
    {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f} = 4'hF;
    Rw_f = 5'd5;
    result_f = 32'h0000FFFF;
    Ra = 5'd5;
    Rb = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    check("reset busA", busA, 32'h0);
    check("reset busB", busB, 32'h0);
    check_status("reset", 1'b0, 5'd0, 8'd0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1 idle();
      #1;
      check($sformatf("vec%0d busA", i), busA, vecs[i].ea);
      check($sformatf("vec%0d busB", i), busB, vecs[i].ea);
      check_status($sformatf("vec%0d", i), vecs[i].ee, vecs[i].erw, vecs[i].ec);
    end

    @(negedge clk);
    Ra = 5'd3;
    Rb = 5'd4;
    #1;
    check("split busA", busA, 32'hCAFEBABE);
    check("split busB", busB, 32'h11CDEFAA);

    // same-cycle read of a register being written
    @(negedge clk);
    MemtoReg_f = 1'b0;
    result_f = 32'h00000055;
    Rw_f = 5'd9;
    RegWr_f = 1'b1;
    {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f} = 4'hF;
    Ra = 5'd9;
    Rb = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass pre busA", busA, 32'h00000055);
    check("bypass pre busB", busB, 32'h00000055);
`else
    check("bypass pre busA", busA, 32'h00000000);
    check("bypass pre busB", busB, 32'h00000000);
`endif
    @(posedge clk);
    #1 idle();
    #1;
    check("bypass post busA", busA, 32'h00000055);

    @(negedge clk);
    result_f = 32'h00000077;
    RegWr_f = 1'b1;
    {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f} = 4'hF;
    OvSel_f = 1'b1;
    overflow_f = 1'b1;
    #1;
    check("trap nobypass busA", busA, 32'h00000055);
    @(posedge clk);
    #1 idle();
    #1;
    check("trap post busA", busA, 32'h00000055);
    check_status("trap9", 1'b1, 5'd9, 8'd4);

    @(negedge clk);
    result_f = 32'hDEADBEEF;
    Rw_f = 5'd0;
    RegWr_f = 1'b1;
    {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f} = 4'hF;
    Ra = 5'd0;
    Rb = 5'd0;
    #1;
    check("r0 pre busA", busA, 32'h0);
    check("r0 pre busB", busB, 32'h0);
    @(posedge clk);
    #1 idle();

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      Rw_f = 5'd12;
      RegWr_f = 1'b1;
      OvSel_f = 1'b1;
      overflow_f = 1'b1;
      @(posedge clk);
    end
    #1 idle();
    #1;
    check_status("saturate", 1'b1, 5'd12, 8'd255);

    @(negedge clk);
    rst_n = 1'b0;
    result_f = 32'h00000001;
    Rw_f = 5'd3;
    RegWr_f = 1'b1;
    {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f} = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    Ra = 5'd3;
    Rb = 5'd4;
    #1;
    check("midreset busA", busA, 32'h0);
    check("midreset busB", busB, 32'h0);
    check_status("midreset", 1'b0, 5'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
